// File: rtl/spandex_msg_tx.sv
// Spandex message transmit serializer: captures one header(+line) message and
// streams it as a head-first, tail-marked flit sequence over valid/ready.
module spandex_msg_tx #(
  parameter int FLIT_W     = 64,
  parameter int LINE_WORDS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         msg_valid,
  output logic                         msg_ready,
  input  logic [FLIT_W-1:0]            msg_header,
  input  logic [FLIT_W*LINE_WORDS-1:0] msg_data,
  input  logic                         msg_has_data,
  output logic                         flit_valid,
  input  logic                         flit_ready,
  output logic [FLIT_W-1:0]            flit_data,
  output logic                         flit_head,
  output logic                         flit_tail,
  output logic                         busy
);

  localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [FLIT_W-1:0]            hdr_q;
  logic [FLIT_W*LINE_WORDS-1:0] data_q;
  logic                         has_data_q;
  logic                         capture;
  logic                         last_hs;

  logic [FLIT_W-1:0] words [LINE_WORDS];

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
    assign words[gi] = data_q[gi*FLIT_W +: FLIT_W];
  end

  // Handshake of the final flit of the held message; frees the slot this cycle.
  assign last_hs = flit_ready &&
                   (((state_q == S_HEAD) && !has_data_q) ||
                    ((state_q == S_DATA) && (idx_q == LAST_IDX)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hdr_q      <= '0;
      data_q     <= '0;
      has_data_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        hdr_q      <= msg_header;
        data_q     <= msg_data;
        has_data_q <= msg_has_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (msg_valid) begin
          capture = 1'b1;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (flit_ready && has_data_q) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (flit_ready && (idx_q != LAST_IDX)) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new message can ride in on the cycle the old tail leaves.
    if (last_hs) begin
      if (msg_valid) begin
        capture = 1'b1;
        state_d = S_HEAD;
      end else begin
        state_d = S_IDLE;
      end
    end
    if (capture) begin
      idx_d = '0;
    end
  end

  always_comb begin
    flit_valid = 1'b0;
    flit_head  = 1'b0;
    flit_tail  = 1'b0;
    flit_data  = '0;
    msg_ready  = 1'b0;
    case (state_q)
      S_IDLE: msg_ready = 1'b1;
      S_HEAD: begin
        flit_valid = 1'b1;
        flit_head  = 1'b1;
        flit_tail  = !has_data_q;
        flit_data  = hdr_q;
      end
      S_DATA: begin
        flit_valid = 1'b1;
        flit_tail  = (idx_q == LAST_IDX);
        flit_data  = words[idx_q];
      end
      default: ;
    endcase
    if (flit_valid && flit_tail && flit_ready) begin
      msg_ready = 1'b1;
    end
  end

  assign busy = (state_q != S_IDLE);

  a_flit_hold: assert property (@(posedge clk) disable iff (!rst)
    flit_valid && !flit_ready |=> flit_valid && $stable(flit_data) &&
                                  $stable(flit_head) && $stable(flit_tail));

  a_idx_range: assert property (@(posedge clk) disable iff (!rst)
    idx_q <= LAST_IDX);

endmodule

// File: tb/tb_spandex_msg_tx.sv
// Bench for spandex_msg_tx: directed scenarios plus random traffic, checked
// against a queue of the flits each accepted message must still produce.
module tb_spandex_msg_tx;
  localparam int FLIT_W = 64;
  localparam int LW     = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               msg_valid;
  logic               msg_ready;
  logic [FLIT_W-1:0]  msg_header;
  logic [FLIT_W*LW-1:0] msg_data;
  logic               msg_has_data;
  logic               flit_valid;
  logic               flit_ready;
  logic [FLIT_W-1:0]  flit_data;
  logic               flit_head;
  logic               flit_tail;
  logic               busy;

  spandex_msg_tx #(.FLIT_W(FLIT_W), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_header(msg_header), .msg_data(msg_data), .msg_has_data(msg_has_data),
    .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_data(flit_data), .flit_head(flit_head), .flit_tail(flit_tail),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic              head;
    logic              tail;
  } flit_t;

  flit_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected flit sequence of one message.
  task automatic push_msg(input logic [FLIT_W-1:0] hdr, input logic [FLIT_W*LW-1:0] data,
                          input logic hd);
    flit_t f;
    f.data = hdr; f.head = 1'b1; f.tail = !hd;
    exp_q.push_back(f);
    if (hd) begin
      for (int i = 0; i < LW; i++) begin
        f.data = data[i*FLIT_W +: FLIT_W];
        f.head = 1'b0;
        f.tail = (i == LW - 1);
        exp_q.push_back(f);
      end
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input logic mv, input logic [FLIT_W-1:0] hdr,
                      input logic [FLIT_W*LW-1:0] data, input logic hd,
                      input logic fr, output logic acc);
    logic nonempty, exp_mr;
    @(negedge clk);
    msg_valid = mv; msg_header = hdr; msg_data = data; msg_has_data = hd; flit_ready = fr;
    #1;
    nonempty = (exp_q.size() != 0);
    exp_mr   = !nonempty || ((exp_q.size() == 1) && fr);
    check("flit_valid", 64'(flit_valid), 64'(nonempty));
    check("busy", 64'(busy), 64'(nonempty));
    check("msg_ready", 64'(msg_ready), 64'(exp_mr));
    if (nonempty) begin
      check("flit_data", flit_data, exp_q[0].data);
      check("flit_head", 64'(flit_head), 64'(exp_q[0].head));
      check("flit_tail", 64'(flit_tail), 64'(exp_q[0].tail));
      $display("cycle flit data=0x%0h head=%0b tail=%0b ready=%0b", flit_data, flit_head, flit_tail, fr);
    end
    acc = mv && exp_mr;
    @(posedge clk);
    if (nonempty && fr) void'(exp_q.pop_front());
    if (acc) begin
      push_msg(hdr, data, hd);
      $display("msg accepted hdr=0x%0h has_data=%0b", hdr, hd);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(flit_valid), 64'd0);
    check({tag, "_head"}, 64'(flit_head), 64'd0);
    check({tag, "_tail"}, 64'(flit_tail), 64'd0);
    check({tag, "_data"}, flit_data, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(msg_ready), 64'd1);
  endtask

  logic acc;
  logic [FLIT_W-1:0]    r_hdr;
  logic [FLIT_W*LW-1:0] r_data;
  logic                 r_hd;
  logic                 have;
  int                   accepted;
  int                   cyc;

  initial begin
    rst = 1'b0; msg_valid = 1'b0; msg_header = '0; msg_data = '0;
    msg_has_data = 1'b0; flit_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Header-only message: one flit, msg_ready high throughout.
    step(1'b1, 64'hA5, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Data message with backpressure on word 0x11, second message pending.
    step(1'b1, 64'h10, {64'h22, 64'h11}, 1'b1, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++) step(1'b1, 64'h20, {64'h2B, 64'h2A}, 1'b1, 1'b0, acc);
    step(1'b1, 64'h20, {64'h2B, 64'h2A}, 1'b1, 1'b1, acc);
    step(1'b1, 64'h20, {64'h2B, 64'h2A}, 1'b1, 1'b1, acc);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("drain1_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream while the second data word is presented.
    step(1'b1, 64'h30, {64'h32, 64'h31}, 1'b1, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    @(negedge clk);
    flit_ready = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 64'h40, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // Random traffic under random backpressure.
    accepted = 0; cyc = 0; have = 1'b0;
    r_hdr = '0; r_data = '0; r_hd = 1'b0;
    while (accepted < 100 && cyc < 5000) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        r_hdr  = {$urandom, $urandom};
        r_data = {$urandom, $urandom, $urandom, $urandom};
        r_hd   = 1'($urandom_range(0, 1));
        have   = 1'b1;
      end
      step(have, r_hdr, r_data, r_hd, ($urandom_range(0, 9) < 7), acc);
      if (acc) begin
        have = 1'b0;
        accepted++;
      end
      cyc++;
    end
    check("rand_accepted", 64'(accepted), 64'd100);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      cyc++;
    end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spandex_msg_tx.md
# spandex_msg_tx

Transmit-side serializer for Spandex cache-to-NoC traffic. Accepts one whole message (header plus an optional cache line) over a valid/ready request port and emits it as a head-first, tail-marked flit stream on a valid/ready NoC output channel. It is the sending end of the channels whose receivers use the team's valid/ready interface controller. It holds the message locally, so the upstream cache FSM is released as soon as the message is captured.

## Interface
Parameters:
- FLIT_W, 64, width of one flit, header word and data word
- LINE_WORDS, 2, data flits per data-carrying message (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- msg_valid  in  1  upstream message present
- msg_ready  out  1  message accepted this cycle when msg_valid && msg_ready
- msg_header  in  FLIT_W  header flit contents
- msg_data  in  FLIT_W*LINE_WORDS  line data; word i = bits [i*FLIT_W +: FLIT_W]
- msg_has_data  in  1  1 = header followed by LINE_WORDS data flits; 0 = header only
- flit_valid  out  1  flit_data/head/tail valid
- flit_ready  in  1  downstream accepts the flit when flit_valid && flit_ready
- flit_data  out  FLIT_W  current flit
- flit_head  out  1  current flit is the header
- flit_tail  out  1  current flit is the last of its message
- busy  out  1  a message is held (state != IDLE)

## Operation
- Capture registers: hdr_q, data_q, has_data_q, loaded on every message handshake.
- Word index idx_q, width clog2(LINE_WORDS) (min 1).
- FSM states:
  - IDLE: flit_valid=0; msg_ready=1. On msg_valid, capture and go to HEAD.
  - HEAD: flit_valid=1, flit_data=hdr_q, flit_head=1, flit_tail=!has_data_q. On flit_ready, go to DATA with idx_q=0 if has_data_q. Otherwise it is the last flit.
  - DATA: flit_valid=1, flit_data=data_q word idx_q, flit_head=0, flit_tail=(idx_q==LINE_WORDS-1). On flit_ready: if not tail, idx_q+1; if tail, it is the last flit.
- Last-flit handshake (tail flit && flit_ready):
  - If msg_valid is also high, capture the new message in the same cycle and go to HEAD. msg_ready is 1 in this case.
  - Otherwise go to IDLE.
- msg_ready = (state==IDLE) || (flit_valid && flit_tail && flit_ready). It is combinational from flit_ready. This is the only combinational in-to-out path.
- flit_valid, flit_head and flit_tail decode the registered state. flit_data is a mux of registers only.
- Once flit_valid is asserted it stays high, and flit_data/head/tail stay stable, until flit_ready is seen.
- msg_data and msg_has_data are ignored when msg_valid is low. Inputs are sampled only on the handshake.
- idx_q never exceeds LINE_WORDS-1. It is reset to 0 on every capture.

## Timing
- Reset (rst low, asynchronous): state=IDLE, idx_q=0, capture registers=0.
  - Outputs: flit_valid=0, flit_head=0, flit_tail=0, flit_data=0, busy=0, msg_ready=1.
  - Applies immediately, even mid-message. A partially sent message is dropped and no further flits of it are sent.
- Latency: a message accepted in cycle N presents its head flit in cycle N+1.
- Throughput with flit_ready held at 1:
  - Header-only messages: 1 per cycle.
  - Data messages: 1 per (1+LINE_WORDS) cycles, with no idle bubble between messages.
- Backpressure: flit_ready=0 freezes state, idx_q and all flit outputs. msg_ready=0 while busy, except in the last-flit handshake cycle.
- LINE_WORDS=1: DATA lasts exactly one accepted flit, which carries flit_tail=1.

## Test plan
- Reset mid-stream: assert rst while in DATA with idx_q=1 -> flit_valid=0 and msg_ready=1 in the same cycle. After release, the next message starts with a head flit.
- Header-only message, hdr=0xA5, flit_ready=1 -> one flit in cycle N+1: data=0xA5, head=1, tail=1. msg_ready is 1 in every cycle, including the flit-handshake cycle.
- Data message, hdr=0x10, data={0x22,0x11}, LINE_WORDS=2, flit_ready=1 -> three consecutive flits: 0x10 (head=1, tail=0), 0x11 (head=0, tail=0), 0x22 (head=0, tail=1). msg_ready=0 in the 0x10 and 0x11 cycles.
- Backpressure: hold flit_ready=0 for 5 cycles while flit 0x11 is presented -> flit_data, head and tail are stable, msg_ready=0, and a pending msg_valid is not accepted. After release the sequence completes unchanged.
- Back-to-back: second data message (hdr=0x20) held valid during the tail of the first -> captured in the tail-handshake cycle. Head 0x20 appears the next cycle with no gap. 100 random messages under random flit_ready arrive in order, each with exactly one head and one tail and no lost or duplicated flits.
